mux_scan_reg: RTL

- Parametrised, registered N-channel by W-bit multiplexer. It is the clocked successor of the combinational 2:1/4:1/8:1 mux trees.
- Two modes: manual select, and automatic round-robin scan with a programmable dwell time and a per-channel skip mask.
- Used to time-share one display or output bus among several data sources. Output and channel index are registered and always mutually consistent.

---
 rtl/mux_scan_reg_if.sv | 27 ++
 rtl/mux_scan_reg.sv | 99 +++++++++
 2 files changed

// File: rtl/mux_scan_reg_if.sv
// Bus bundle for mux_scan_reg: packed channel inputs, selection controls,
// and the registered output/index pair with its status flags.
interface mux_scan_reg_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3
);
  logic                      en;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [CHANNELS-1:0]       mask;
  logic [CHANNELS*WIDTH-1:0] d;
  logic [WIDTH-1:0]          y;
  logic [SEL_W-1:0]          ch;
  logic                      strobe;
  logic                      none_active;

  modport master (
    output en, mode, sel, mask, d,
    input  y, ch, strobe, none_active
  );

  modport slave (
    input  en, mode, sel, mask, d,
    output y, ch, strobe, none_active
  );
endinterface

// File: rtl/mux_scan_reg.sv
// Registered N-channel mux with manual select or round-robin scan
// (programmable dwell, per-channel skip mask); y and ch always agree.
module mux_scan_reg #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3,
  parameter int DWELL    = 4
) (
  input logic            clk,
  input logic            rst_n,
  mux_scan_reg_if.slave  bus
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [WIDTH-1:0] chan [CHANNELS];

  logic [WIDTH-1:0] y_q;
  logic [SEL_W-1:0] ch_q;
  logic [CNT_W-1:0] cnt_q;
  logic             strobe_q;
  logic             none_q;

  logic [WIDTH-1:0] y_next;
  logic [SEL_W-1:0] ch_next;
  logic [CNT_W-1:0] cnt_next;
  logic [SEL_W-1:0] scan_next;
  logic             sel_ok;
  logic             mask_empty;
  logic             cnt_last;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    assign chan[i] = bus.d[i*WIDTH +: WIDTH];
  end

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    sel_ok = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.sel == SEL_W'(i)) sel_ok = 1'b1;
    end

    // First set mask bit strictly after ch, circularly; ch itself if none.
    scan_next = ch_q;
    for (int k = CHANNELS - 1; k >= 1; k--) begin
      int idx;
      idx = int'(ch_q) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (bus.mask[SEL_W'(idx)]) scan_next = SEL_W'(idx);
    end

    mask_empty = (bus.mask == '0);
    cnt_last   = (cnt_q == CNT_W'(DWELL - 1));

    ch_next  = ch_q;
    cnt_next = cnt_q;
    if (!bus.mode) begin
      if (sel_ok) ch_next = bus.sel;
      cnt_next = '0;
    end else if (mask_empty) begin
      cnt_next = '0;
    end else if (none_q || !bus.mask[ch_q] || cnt_last) begin
      // Leaving an empty mask, or the current channel was dropped, or dwell done.
      ch_next  = scan_next;
      cnt_next = '0;
    end else begin
      cnt_next = cnt_q + CNT_W'(1);
    end

    y_next = (bus.mode && mask_empty) ? '0 : chan[ch_next];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q      <= '0;
      ch_q     <= '0;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
      none_q   <= 1'b0;
    end else if (bus.en) begin
      y_q      <= y_next;
      ch_q     <= ch_next;
      cnt_q    <= cnt_next;
      strobe_q <= (ch_next != ch_q);
      none_q   <= bus.mode && mask_empty;
    end else begin
      strobe_q <= 1'b0;
    end
  end

  assign bus.y           = y_q;
  assign bus.ch          = ch_q;
  assign bus.strobe      = strobe_q;
  assign bus.none_active = none_q;

endmodule
